// File: rtl/mix_columns_seq.sv
// AES MixColumns, one column per cycle, with a bypass for the final round.
// A captured state word is transformed in place, column 0 first. The finished
// word is then held on out_data until the downstream stage takes it.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [1:0]     col_cnt_q;
  logic [127:0]   data_q;
  logic [127:0]   data_d;
  logic [6:0]     col_lsb;
  logic           in_ready_q;
  logic           out_valid_q;

  // Multiplication by 2 in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Transform one column; row 0 is the most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // Column c lives at bits [127-32c -: 32], so its LSB is 32*(3-c).
  assign col_lsb = {~col_cnt_q, 5'b00000};

  // Next state word: current column replaced by its transform, others held.
  always_comb begin
    // NOTE: data_d gets a full default before the partial update, so no
    // bits are left unassigned on any path and no latch is inferred.
    data_d                 = data_q;
    data_d[col_lsb +: 32]  = mix_col(data_q[col_lsb +: 32]);
  end

  // Control FSM with registered handshake outputs and the state word.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, because out_data must read
      // zero while reset is asserted.
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      data_q      <= 128'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      // Abort wins over any handshake on this edge; the word is dropped.
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            col_cnt_q  <= 2'd0;
            in_ready_q <= 1'b0;
            if (in_last) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          data_q    <= data_d;
          col_cnt_q <= col_cnt_q + 2'd1;
          if (col_cnt_q == 2'd3) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Return to IDLE only; acceptance waits for the following edge.
          if (out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          col_cnt_q   <= 2'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: known answers, bypass, backpressure, flush,
// asynchronous reset and back-to-back throughput, using a result queue.
module tb_mix_columns_seq;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_last   = 1'b0;
  logic         flush     = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_data   = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;

  localparam logic [127:0] KAT1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] KAT1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] KAT2_IN  = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
  localparam logic [127:0] KAT2_OUT = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [127:0] exp_q[$];

  mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference MixColumns as a matrix product over GF(2^8).
  function automatic logic [127:0] model(input logic [127:0] d);
    logic [7:0] m [4][4] = '{'{8'd2, 8'd3, 8'd1, 8'd1},
                             '{8'd1, 8'd2, 8'd3, 8'd1},
                             '{8'd1, 8'd1, 8'd2, 8'd3},
                             '{8'd3, 8'd1, 8'd1, 8'd2}};
    logic [127:0] r = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(d[127 - 32*c - 8*k -: 8], m[row][k]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Present one word at a negedge while idle; returns at the negedge after
  // the acceptance edge. The expected result goes on the queue.
  task automatic accept(input logic [127:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    exp_q.push_back(last ? d : model(d));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Count edges (acceptance edge = 1) until out_valid is seen, bounded.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 128'h0) begin
      errors++; $display("FAIL reset_out_data got %h want 0", out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_kat(input string name, input logic [127:0] din,
                          input logic [127:0] dout);
    int n;
    logic [127:0] e;
    out_ready = 1'b1;
    accept(din, 1'b0);
    wait_valid(n);
    checks++;
    if (!out_valid || n != 5) begin
      errors++; $display("FAIL %s_latency got %0d valid %b want 5", name, n, out_valid);
    end
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) begin
      errors++; $display("FAIL %s_model got %h want %h", name, out_data, e);
    end
    checks++;
    if (out_data !== dout) begin
      errors++; $display("FAIL %s_answer got %h want %h", name, out_data, dout);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_one_cycle got valid %b ready %b want 0 1",
                         name, out_valid, in_ready);
    end
  endtask

  task automatic test_bypass;
    int n;
    logic [127:0] e;
    accept(KAT1_IN, 1'b1);
    wait_valid(n);
    checks++;
    if (!out_valid || n != 1) begin
      errors++; $display("FAIL bypass_latency got %0d valid %b want 1", n, out_valid);
    end
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) begin
      errors++; $display("FAIL bypass_data got %h want %h", out_data, e);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bypass_release got valid %b ready %b want 0 1",
                         out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure;
    int n;
    int bad = 0;
    logic [127:0] e;
    logic [127:0] snap;
    out_ready = 1'b0;
    accept(KAT2_IN, 1'b0);
    wait_valid(n);
    e = exp_q.pop_front();
    checks++;
    if (!out_valid || out_data !== e) begin
      errors++; $display("FAIL bp_data got %h valid %b want %h", out_data, out_valid, e);
    end
    snap = out_data;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = ~KAT1_IN;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== snap || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid %b ready %b want 0 1",
                         out_valid, in_ready);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_ignored got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_flush;
    int bad = 0;
    accept(KAT1_IN, 1'b0);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle got ready %b valid %b want 1 0",
                         in_ready, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL flush_no_output got %0d valid cycles want 0", bad);
    end
    test_kat("flush_kat", KAT1_IN, KAT1_OUT);
  endtask

  task automatic test_async_reset;
    int n;
    logic [127:0] e;
    accept(KAT2_IN, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_flags got ready %b valid %b want 1 0",
                         in_ready, out_valid);
    end
    checks++;
    if (out_data !== 128'h0) begin
      errors++; $display("FAIL areset_data got %h want 0", out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    accept(KAT1_IN, 1'b0);
    wait_valid(n);
    checks++;
    if (!out_valid || n != 5) begin
      errors++; $display("FAIL areset_first_latency got %0d valid %b want 5", n, out_valid);
    end
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) begin
      errors++; $display("FAIL areset_first_data got %h want %h", out_data, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back(input logic last, input int gap);
    out_ready = 1'b1;
    fork
      begin : drive
        for (int i = 0; i < 3; i++) begin
          int t = 0;
          in_valid = 1'b1;
          in_last  = last;
          in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
          exp_q.push_back(last ? in_data : model(in_data));
          while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      begin : watch
        int prev = 0;
        for (int k = 0; k < 3; k++) begin
          int t = 0;
          logic [127:0] e;
          @(negedge clk);
          while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
          end
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
          checks++;
          if (!out_valid || out_data !== e) begin
            errors++; $display("FAIL b2b_data last=%0b #%0d got %h want %h",
                               last, k, out_data, e);
          end
          if (k > 0) begin
            checks++;
            if (cyc - prev != gap) begin
              errors++; $display("FAIL b2b_gap last=%0b #%0d got %0d want %0d",
                                 last, k, cyc - prev, gap);
            end
          end
          prev = cyc;
        end
      end
    join
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_kat("kat1", KAT1_IN, KAT1_OUT);
    test_kat("kat2", KAT2_IN, KAT2_OUT);
    test_bypass();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back(1'b0, 6);
    test_back_to_back(1'b1, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
